descriptor_delay_queue: RTL and testbench

//  Multi-entry successor to the single-descriptor delay stage between forwarding lookup and output queueing.

---
 rtl/descriptor_delay_queue.sv | 62 ++++++
 tb/tb_descriptor_delay_queue.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/descriptor_delay_queue.sv
// descriptor_delay_queue: FIFO of descriptors, each held back until its own programmed delay has elapsed
module descriptor_delay_queue #(
    parameter int DW    = 46,
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CW    = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [CW-1:0] iv_delay_cycle,
    input  logic [DW-1:0] iv_descriptor,
    input  logic          i_descriptor_wr,
    output logic          o_descriptor_ack,
    output logic [DW-1:0] ov_descriptor,
    output logic          o_descriptor_wr,
    input  logic          i_descriptor_ack,
    output logic          o_full,
    output logic [AW:0]   ov_occupancy,
    output logic [15:0]   ov_drop_cnt
);
    typedef enum logic {IDLE_S, PRESENT_S} state_t;
    state_t        state;
    logic [DW-1:0] mem [DEPTH];
    logic [CW-1:0] cnt [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] load;
    logic          push, pop;
    // counters store remaining delay minus one, so an entry written at edge T expires for the edge T+D
    assign load             = iv_delay_cycle == '0 ? '0 : iv_delay_cycle - CW'(1);
    assign o_full           = ov_occupancy == (AW+1)'(DEPTH);
    assign push             = i_descriptor_wr & ~o_full;
    assign pop              = (state == PRESENT_S) & i_descriptor_ack;
    assign o_descriptor_ack = push;
    always_ff @(posedge i_clk) if (push) mem[wr_ptr] <= iv_descriptor;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= IDLE_S;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            ov_occupancy    <= '0;
            ov_drop_cnt     <= '0;
            ov_descriptor   <= '0;
            o_descriptor_wr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                cnt[i] <= (push && wr_ptr == AW'(i)) ? load : (cnt[i] == '0 ? '0 : cnt[i] - CW'(1));
            if (push) wr_ptr <= wr_ptr + AW'(1);
            ov_occupancy <= ov_occupancy + (AW+1)'(push) - (AW+1)'(pop);
            if (i_descriptor_wr && o_full && ov_drop_cnt != 16'hFFFF) ov_drop_cnt <= ov_drop_cnt + 16'd1;
            if (state == IDLE_S && ov_occupancy != '0 && cnt[rd_ptr] == '0) begin
                ov_descriptor   <= mem[rd_ptr];
                o_descriptor_wr <= 1'b1;
                state           <= PRESENT_S;
            end else if (pop) begin
                o_descriptor_wr <= 1'b0;
                rd_ptr          <= rd_ptr + AW'(1);
                state           <= IDLE_S;
            end
        end
    end
endmodule

// File: tb/tb_descriptor_delay_queue.sv
// tb_descriptor_delay_queue: directed and random traffic checked against a ready-time queue model
module tb_descriptor_delay_queue;
    localparam int DW = 46, DEPTH = 8, AW = 3, CW = 8;
    logic          clk = 0, rst = 1, wr = 0, ack = 0;
    logic [CW-1:0] dly = '0;
    logic [DW-1:0] wdata = '0;
    logic          o_ack, o_wr, o_full;
    logic [DW-1:0] o_desc;
    logic [AW:0]   o_occ;
    logic [15:0]   o_drop;
    int total = 0, bad = 0;

    descriptor_delay_queue #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .i_clk(clk), .i_rst(rst), .iv_delay_cycle(dly), .iv_descriptor(wdata),
        .i_descriptor_wr(wr), .o_descriptor_ack(o_ack), .ov_descriptor(o_desc),
        .o_descriptor_wr(o_wr), .i_descriptor_ack(ack), .o_full(o_full),
        .ov_occupancy(o_occ), .ov_drop_cnt(o_drop)
    );

    always #4 clk = ~clk;

    typedef struct {logic [DW-1:0] d; int at;} ent_t;
    ent_t mq[$];
    ent_t sb[$];
    int edge_n = 0, drop_m = 0, n0;
    bit pres_m = 0, armed = 0, pop_m, start_m, prev_wr = 0;
    logic [DW-1:0] cur_m = '0;

    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at edge %0d", n, a, e, edge_n);
        end
    endtask

    // model: each entry becomes eligible at write edge + max(delay,1); one presented at a time, in order
    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            mq.delete(); sb.delete();
            pres_m = 0; drop_m = 0; cur_m = '0; armed = 1;
        end else begin
            n0 = mq.size();
            pop_m = pres_m && ack;
            start_m = !pres_m && n0 > 0 && mq[0].at <= edge_n;
            if (wr) begin
                if (n0 == DEPTH) begin
                    if (drop_m != 65535) drop_m++;
                end else mq.push_back('{d: wdata, at: edge_n + (dly == 0 ? 1 : int'(dly))});
            end
            if (start_m) begin
                pres_m = 1; cur_m = mq[0].d;
                sb.push_back('{d: mq[0].d, at: edge_n});
            end
            if (pop_m) begin
                void'(mq.pop_front());
                pres_m = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("valid", o_wr, pres_m);
            chk("desc", o_desc, cur_m);
            chk("occupancy", o_occ, mq.size());
            chk("full", o_full, mq.size() == DEPTH);
            chk("drop_cnt", o_drop, drop_m);
            chk("wr_ack", o_ack, wr && mq.size() < DEPTH);
            if (o_wr && !prev_wr) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_present: got %0h want none", o_desc);
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    chk("order", o_desc, e.d);
                    chk("present_edge", edge_n, e.at);
                end
            end
            prev_wr = o_wr;
        end
    end

    task automatic cyc(bit w, logic [DW-1:0] d, logic [CW-1:0] dl, bit a);
        wr = w; wdata = d; dly = dl; ack = a;
        @(posedge clk); #1;
    endtask

    task automatic idle(int n, bit a);
        repeat (n) cyc(0, '0, '0, a);
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'({$urandom(), $urandom()});
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_valid", o_wr, 0);
        chk("rst_desc", o_desc, 0);
        chk("rst_full", o_full, 0);
        chk("rst_occ", o_occ, 0);
        chk("rst_drop", o_drop, 0);
        // single write, delay 10
        cyc(1, 46'h1234_5678_9AB, 10, 1);
        idle(9, 1);
        chk("d10_early", o_wr, 0);
        idle(1, 1);
        chk("d10_rise", o_wr, 1);
        chk("d10_data", o_desc, 46'h1234_5678_9AB);
        idle(1, 1);
        chk("d10_fall", o_wr, 0);
        idle(3, 1);
        // zero delay behaves as one
        cyc(1, 46'h2AAA, 0, 1);
        chk("d0_t", o_wr, 0);
        idle(1, 1);
        chk("d0_t1", o_wr, 1);
        idle(4, 1);
        // back-to-back writes, ack tied high
        for (int i = 0; i < 4; i++) cyc(1, 46'hA0 + DW'(i), 4, 1);
        idle(15, 1);
        // fill under back-pressure, long stall, drops
        for (int i = 0; i < DEPTH; i++) cyc(1, 46'hB00 + DW'(i), CW'(3 + i), 0);
        idle(1000, 0);
        chk("stall_occ", o_occ, 8);
        chk("stall_full", o_full, 1);
        wr = 1; wdata = 46'hDEAD; #1;
        chk("full_wr_ack", o_ack, 0);
        cyc(1, 46'hDEAD, 1, 0);
        cyc(1, 46'hDEAD, 1, 0);
        cyc(1, 46'hDEAD, 1, 0);
        chk("drop3", o_drop, 3);
        idle(30, 1);
        // full queue: write and ack in the same cycle
        for (int i = 0; i < DEPTH; i++) cyc(1, 46'hC00 + DW'(i), 2, 0);
        idle(2, 0);
        cyc(1, 46'hBEEF, 2, 1);
        chk("full_pop_occ", o_occ, 7);
        chk("full_pop_drop", o_drop, 4);
        idle(30, 1);
        // reset while presenting
        for (int i = 0; i < 5; i++) cyc(1, 46'hD00 + DW'(i), 1, 0);
        idle(2, 0);
        chk("pre_rst_wr", o_wr, 1);
        rst = 1;
        cyc(0, '0, '0, 0);
        rst = 0;
        chk("post_rst_wr", o_wr, 0);
        chk("post_rst_occ", o_occ, 0);
        cyc(1, 46'hE01, 3, 1);
        idle(2, 1);
        chk("d3_early", o_wr, 0);
        idle(1, 1);
        chk("d3_rise", o_wr, 1);
        idle(5, 1);
        // random traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 1) == 1, rnd(), CW'($urandom_range(0, 12)), $urandom_range(0, 9) < 6);
        idle(400, 1);
        chk("drained", o_occ, 0);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
